// File: rtl/cpu_seq_unit.sv
// ============================================================================
// Module      : cpu_seq_unit
// Description : Multi-cycle CPU sequencer (fetch / execute / trap) with
//               prioritised interrupts, multi-unit completion tracking and
//               retired-instruction counter. Optional execute watchdog is
//               enabled by defining CU_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_seq_unit #(
    parameter int NUM_MC     = 3,
    parameter int NUM_IRQ    = 2,
    parameter int LVL_W      = 2,
    parameter int WDT_CYCLES = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_bus_DV,
    input  logic [NUM_MC-1:0] i_mc_req,
    input  logic [NUM_MC-1:0] i_mc_done,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic              i_trap_done,
    output logic [1:0]        o_state,
    output logic              o_load_PC,
    output logic              o_start_fetch,
    output logic              o_trap_start,
    output logic [LVL_W-1:0]  o_trap_level,
    output logic [31:0]       o_instret
);

    generate
        if (WDT_CYCLES < 2 || (1 << LVL_W) < (NUM_IRQ + 1)) begin : g_param_check
            $error("cpu_seq_unit: illegal WDT_CYCLES or LVL_W too narrow for NUM_IRQ+1 levels");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_boot;
    logic               r_start_fetch;
    logic               r_trap_start;
    logic [LVL_W-1:0]   r_trap_level;
    logic [31:0]        r_instret;

    logic               w_done;
    logic               w_irq_any;
    logic [LVL_W-1:0]   w_irq_lvl;
    logic               w_wdt_expire;
    logic               w_load_pc;
    logic               w_retire;
    logic               w_trap_enter;
    logic               w_to_fetch;
    logic [LVL_W-1:0]   w_trap_lvl_nxt;

    // Every requested unit must report done in the same cycle.
    assign w_done    = &(i_mc_done | ~i_mc_req);
    assign w_irq_any = |i_irq;

    // Highest set index wins.
    always_comb begin
        w_irq_lvl = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (i_irq[i]) begin
                w_irq_lvl = LVL_W'(i);
            end
        end
    end

`ifdef CU_WATCHDOG_EN
    localparam int WDT_W = $clog2(WDT_CYCLES);

    logic [WDT_W-1:0] r_wdt;

    // Held at zero outside EXEC, so it starts from zero on each EXEC entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdt <= '0;
        end else if (r_state != ST_EXEC) begin
            r_wdt <= '0;
        end else if (!w_done) begin
            r_wdt <= r_wdt + 1'b1;
        end
    end

    assign w_wdt_expire = (r_state == ST_EXEC) && !w_done &&
                          (r_wdt == WDT_W'(WDT_CYCLES - 1));
`else
    assign w_wdt_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_load_pc      = 1'b0;
        w_retire       = 1'b0;
        w_trap_enter   = 1'b0;
        w_to_fetch     = 1'b0;
        w_trap_lvl_nxt = r_trap_level;
        case (r_state)
            ST_FETCH: begin
                if (i_bus_DV) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Normal completion takes precedence over watchdog expiry.
                if (w_done) begin
                    w_load_pc = 1'b1;
                    w_retire  = 1'b1;
                    if (w_irq_any) begin
                        w_state_nxt    = ST_TRAP;
                        w_trap_enter   = 1'b1;
                        w_trap_lvl_nxt = w_irq_lvl;
                    end else begin
                        w_state_nxt = ST_FETCH;
                        w_to_fetch  = 1'b1;
                    end
                end else if (w_wdt_expire) begin
                    w_load_pc      = 1'b1;
                    w_state_nxt    = ST_TRAP;
                    w_trap_enter   = 1'b1;
                    w_trap_lvl_nxt = LVL_W'(NUM_IRQ);
                end
            end
            ST_TRAP: begin
                if (i_trap_done) begin
                    w_load_pc   = 1'b1;
                    w_state_nxt = ST_FETCH;
                    w_to_fetch  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_FETCH;
            r_boot        <= 1'b1;
            r_start_fetch <= 1'b0;
            r_trap_start  <= 1'b0;
            r_trap_level  <= '0;
            r_instret     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_boot        <= 1'b0;
            // r_boot only lives in FETCH, so it never coincides with a trap entry.
            r_start_fetch <= r_boot | w_to_fetch;
            r_trap_start  <= w_trap_enter;
            if (w_trap_enter) begin
                r_trap_level <= w_trap_lvl_nxt;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    assign o_state       = r_state;
    assign o_load_PC     = w_load_pc;
    assign o_start_fetch = r_start_fetch;
    assign o_trap_start  = r_trap_start;
    assign o_trap_level  = r_trap_level;
    assign o_instret     = r_instret;

endmodule

`default_nettype wire

// File: tb/tb_cpu_seq_unit.sv
// ============================================================================
// Module      : tb_cpu_seq_unit
// Description : Directed self-checking bench for cpu_seq_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_seq_unit;

    localparam int NUM_MC  = 3;
    localparam int NUM_IRQ = 2;
    localparam int LVL_W   = 2;

    logic               i_clk;
    logic               i_rst;
    logic               i_bus_DV;
    logic [NUM_MC-1:0]  i_mc_req;
    logic [NUM_MC-1:0]  i_mc_done;
    logic [NUM_IRQ-1:0] i_irq;
    logic               i_trap_done;
    logic [1:0]         o_state;
    logic               o_load_PC;
    logic               o_start_fetch;
    logic               o_trap_start;
    logic [LVL_W-1:0]   o_trap_level;
    logic [31:0]        o_instret;

    int n_checks = 0;
    int n_errors = 0;
    int exp_instret = 0;

    cpu_seq_unit #(
        .NUM_MC     (NUM_MC),
        .NUM_IRQ    (NUM_IRQ),
        .LVL_W      (LVL_W),
        .WDT_CYCLES (8)
    ) u_dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_bus_DV      (i_bus_DV),
        .i_mc_req      (i_mc_req),
        .i_mc_done     (i_mc_done),
        .i_irq         (i_irq),
        .i_trap_done   (i_trap_done),
        .o_state       (o_state),
        .o_load_PC     (o_load_PC),
        .o_start_fetch (o_start_fetch),
        .o_trap_start  (o_trap_start),
        .o_trap_level  (o_trap_level),
        .o_instret     (o_instret)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        i_rst       = 1'b1;
        i_bus_DV    = 1'b0;
        i_mc_req    = '0;
        i_mc_done   = '0;
        i_irq       = '0;
        i_trap_done = 1'b0;
        tick;
        tick;
        check_val("rst_state", o_state, 0);
        check_val("rst_sf", o_start_fetch, 0);
        check_val("rst_ts", o_trap_start, 0);
        check_val("rst_lvl", o_trap_level, 0);
        check_val("rst_instret", o_instret, 0);
        check_val("rst_load", o_load_PC, 0);

        // Test 1: boot pulse, single-cycle instruction.
        i_rst = 1'b0;
        tick;
        check_val("boot_sf", o_start_fetch, 1);
        check_val("boot_state", o_state, 0);
        tick;
        check_val("boot_sf_off", o_start_fetch, 0);
        tick;
        i_bus_DV = 1'b1;
        #1;
        check_val("fetch_load", o_load_PC, 0);
        tick;
        i_bus_DV = 1'b0;
        #1;
        check_val("t1_state", o_state, 1);
        check_val("t1_load", o_load_PC, 1);
        check_val("t1_sf", o_start_fetch, 0);
        tick;
        exp_instret = 1;
        check_val("t1_fetch", o_state, 0);
        check_val("t1_sf_pulse", o_start_fetch, 1);
        check_val("t1_instret", o_instret, exp_instret);
        check_val("t1_load_off", o_load_PC, 0);

        // i_trap_done / i_mc_done have no effect in FETCH.
        i_trap_done = 1'b1;
        i_mc_done   = 3'b111;
        #1;
        check_val("fetch_ign_load", o_load_PC, 0);
        tick;
        i_trap_done = 1'b0;
        i_mc_done   = '0;
        check_val("fetch_ign_state", o_state, 0);
        check_val("fetch_ign_sf", o_start_fetch, 0);

        // Test 2: multi-hot request needs both done bits together.
        i_bus_DV = 1'b1;
        i_mc_req = 3'b011;
        tick;
        i_bus_DV = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            if (e > 1) tick;
            i_mc_done = {1'b0, (e == 5), (e >= 2)};
            #1;
            check_val($sformatf("mh_load_e%0d", e), o_load_PC, (e == 5));
            check_val($sformatf("mh_state_e%0d", e), o_state, 1);
        end
        tick;
        i_mc_done = '0;
        i_mc_req  = '0;
        exp_instret = 2;
        check_val("mh_fetch", o_state, 0);
        check_val("mh_sf", o_start_fetch, 1);
        check_val("mh_instret", o_instret, exp_instret);

        // Test 3: both IRQs at completion -> level 1 trap.
        i_bus_DV = 1'b1;
        i_irq    = 2'b11;
        tick;
        i_bus_DV = 1'b0;
        #1;
        check_val("irq_exec_state", o_state, 1);
        check_val("irq_exec_load", o_load_PC, 1);
        tick;
        i_irq = 2'b00;
        exp_instret = 3;
        check_val("trap_state", o_state, 2);
        check_val("trap_ts", o_trap_start, 1);
        check_val("trap_sf", o_start_fetch, 0);
        check_val("trap_lvl", o_trap_level, 1);
        check_val("trap_instret", o_instret, exp_instret);
        for (int t = 2; t <= 5; t++) begin
            tick;
            if (t == 2) i_irq = 2'b10;
            if (t == 5) i_trap_done = 1'b1;
            #1;
            check_val($sformatf("trap_load_t%0d", t), o_load_PC, (t == 5));
            check_val($sformatf("trap_ts_t%0d", t), o_trap_start, 0);
            check_val($sformatf("trap_state_t%0d", t), o_state, 2);
        end
        tick;
        i_trap_done = 1'b0;
        i_irq       = 2'b00;
        check_val("trap_exit_state", o_state, 0);
        check_val("trap_exit_sf", o_start_fetch, 1);
        check_val("trap_exit_ts", o_trap_start, 0);
        check_val("trap_exit_lvl", o_trap_level, 1);

        // Test 4: IRQ only in FETCH / early EXEC is ignored.
        i_irq    = 2'b01;
        i_bus_DV = 1'b1;
        i_mc_req = 3'b100;
        tick;
        i_irq    = 2'b00;
        i_bus_DV = 1'b0;
        #1;
        check_val("t4_state", o_state, 1);
        check_val("t4_load0", o_load_PC, 0);
        tick;
        i_mc_done = 3'b100;
        #1;
        check_val("t4_load1", o_load_PC, 1);
        tick;
        i_mc_done = '0;
        i_mc_req  = '0;
        exp_instret = 4;
        check_val("t4_fetch", o_state, 0);
        check_val("t4_sf", o_start_fetch, 1);
        check_val("t4_ts", o_trap_start, 0);
        check_val("t4_lvl", o_trap_level, 1);
        check_val("t4_instret", o_instret, exp_instret);

        // Level-0 trap.
        i_bus_DV = 1'b1;
        i_irq    = 2'b01;
        tick;
        i_bus_DV = 1'b0;
        #1;
        check_val("l0_load", o_load_PC, 1);
        tick;
        i_irq = 2'b00;
        exp_instret = 5;
        check_val("l0_state", o_state, 2);
        check_val("l0_ts", o_trap_start, 1);
        check_val("l0_lvl", o_trap_level, 0);
        check_val("l0_instret", o_instret, exp_instret);
        i_trap_done = 1'b1;
        #1;
        check_val("l0_trap_load", o_load_PC, 1);
        tick;
        i_trap_done = 1'b0;
        check_val("l0_exit_state", o_state, 0);
        check_val("l0_exit_sf", o_start_fetch, 1);

        // Test 5: reset during EXEC aborts.
        i_bus_DV = 1'b1;
        i_mc_req = 3'b100;
        tick;
        i_bus_DV = 1'b0;
        tick;
        check_val("t5_exec", o_state, 1);
        i_rst = 1'b1;
        tick;
        exp_instret = 0;
        check_val("t5_state", o_state, 0);
        check_val("t5_instret", o_instret, exp_instret);
        check_val("t5_sf", o_start_fetch, 0);
        check_val("t5_ts", o_trap_start, 0);
        check_val("t5_lvl", o_trap_level, 0);
        i_rst    = 1'b0;
        i_mc_req = '0;
        tick;
        check_val("t5_boot_sf", o_start_fetch, 1);
        tick;
        check_val("t5_boot_sf_off", o_start_fetch, 0);

        i_bus_DV = 1'b1;
        i_mc_req = 3'b001;
        tick;
        i_bus_DV = 1'b0;
`ifdef CU_WATCHDOG_EN
        // Test 6: watchdog expiry after 8 EXEC cycles.
        for (int e = 1; e <= 8; e++) begin
            if (e > 1) tick;
            #1;
            check_val($sformatf("wdt_load_e%0d", e), o_load_PC, (e == 8));
            check_val($sformatf("wdt_state_e%0d", e), o_state, 1);
        end
        tick;
        check_val("wdt_trap_state", o_state, 2);
        check_val("wdt_ts", o_trap_start, 1);
        check_val("wdt_lvl", o_trap_level, 2);
        check_val("wdt_instret", o_instret, exp_instret);
        i_trap_done = 1'b1;
        #1;
        check_val("wdt_trap_load", o_load_PC, 1);
        tick;
        i_trap_done = 1'b0;
        check_val("wdt_exit_state", o_state, 0);
        check_val("wdt_exit_sf", o_start_fetch, 1);

        // Done on the expiry cycle wins.
        i_bus_DV = 1'b1;
        tick;
        i_bus_DV = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            if (e > 1) tick;
            i_mc_done = (e == 8) ? 3'b001 : 3'b000;
            #1;
            check_val($sformatf("wdt2_load_e%0d", e), o_load_PC, (e == 8));
        end
        tick;
        i_mc_done = '0;
        i_mc_req  = '0;
        exp_instret = 1;
        check_val("wdt2_state", o_state, 0);
        check_val("wdt2_sf", o_start_fetch, 1);
        check_val("wdt2_ts", o_trap_start, 0);
        check_val("wdt2_instret", o_instret, exp_instret);
        check_val("wdt2_lvl", o_trap_level, 2);
`else
        // Without the watchdog EXEC waits indefinitely.
        for (int e = 1; e <= 20; e++) begin
            if (e > 1) tick;
            #1;
            check_val($sformatf("nowdt_load_e%0d", e), o_load_PC, 0);
            check_val($sformatf("nowdt_state_e%0d", e), o_state, 1);
        end
        i_mc_done = 3'b001;
        #1;
        check_val("nowdt_done_load", o_load_PC, 1);
        tick;
        i_mc_done = '0;
        i_mc_req  = '0;
        exp_instret = 1;
        check_val("nowdt_state", o_state, 0);
        check_val("nowdt_sf", o_start_fetch, 1);
        check_val("nowdt_ts", o_trap_start, 0);
        check_val("nowdt_instret", o_instret, exp_instret);
        check_val("nowdt_lvl", o_trap_level, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
